// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the main-memory arbiter
// and the cache fill/writeback blocks that use it.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    I_RD = 2'd1,
    D_RD = 2'd2,
    D_WR = 2'd3
  } state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_BEAT_W     = 2;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker: on a tie the requester
// that was not granted last wins.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ireq_i,
  input  logic dreq_i,
  input  logic upd_i,
  output logic gnt_o,
  output logic last_o
);

  logic last_q;

  // Winner: lone requester, or the non-last one on a tie.
  always_comb begin
    gnt_o = GNT_I;
    if (ireq_i && dreq_i) begin
      gnt_o = ~last_q;
    end else if (dreq_i) begin
      gnt_o = GNT_D;
    end
  end

  // Remember who got the port; I counts as last after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_I;
    end else if (upd_i) begin
      last_q <= gnt_o;
    end
  end

  assign last_o = last_q;

endmodule

// File: rtl/mem_arbiter.sv
// Unified memory port shared between I-cache fills and
// D-cache fills/writebacks, one line burst per grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int BEAT_W     = DEF_BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic [BEAT_W-1:0] i_beat,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic [BEAT_W-1:0] d_beat,
  output logic              d_done,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy
);

  localparam logic [BEAT_W-1:0] LAST =
    BEAT_W'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              gnt;
  logic              upd;
  logic              last_unused;
  logic              fin;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .ireq_i (i_req),
    .dreq_i (d_req),
    .upd_i  (upd),
    .gnt_o  (gnt),
    .last_o (last_unused)
  );

  assign fin = mem_rdy && (beat_q == LAST);

  // Grant in IDLE, then step beats on each mem_rdy.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    upd       = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_rdata   = '0;
    i_rvalid  = 1'b0;
    i_beat    = '0;
    i_done    = 1'b0;
    d_rdata   = '0;
    d_rvalid  = 1'b0;
    d_beat    = '0;
    d_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          upd    = 1'b1;
          beat_d = '0;
          if (gnt == GNT_D) begin
            base_d  = {d_addr[ADDR_W-1:BEAT_W],
                       {BEAT_W{1'b0}}};
            state_d = d_wr ? D_WR : D_RD;
          end else begin
            base_d  = {i_addr[ADDR_W-1:BEAT_W],
                       {BEAT_W{1'b0}}};
            state_d = I_RD;
          end
        end
      end
      I_RD: begin
        mem_re   = 1'b1;
        i_beat   = beat_q;
        i_rvalid = mem_rdy;
        i_rdata  = mem_rdy ? mem_rdata : '0;
        i_done   = fin;
      end
      D_RD: begin
        mem_re   = 1'b1;
        d_beat   = beat_q;
        d_rvalid = mem_rdy;
        d_rdata  = mem_rdy ? mem_rdata : '0;
        d_done   = fin;
      end
      D_WR: begin
        mem_we    = 1'b1;
        mem_wdata = d_wdata;
        d_beat    = beat_q;
        d_done    = fin;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE) begin
      mem_addr = {base_q[ADDR_W-1:BEAT_W], beat_q};
      if (mem_rdy) begin
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == LAST) begin
          state_d = IDLE;
        end
      end
    end
  end

  // Burst state, beat index and latched line base.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
    end
  end

endmodule
